id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with forwarding-select generation and load-use hazard detection for the 5-stage RV32I core. It captures decoded operands and control from the decode stage each cycle. It drives the EX-stage ALU wrapper's operand, immediate, ALU-source and ALU-opcode inputs, and its two 2-bit forwarding selects. It also raises `stall` to freeze PC and IF/ID on a load-use hazard, and accepts a flush from branch resolution.

## Interface
- `XLEN`, 32, datapath width
- `REGW`, 5, register-index width
- `clk` in 1: rising-edge clock
- `reset_n` in 1: asynchronous, active-low reset
- `id_valid` in 1: decode stage holds a real instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN: decoded PC, register-file reads, immediate
- `id_rs1`, `id_rs2`, `id_rd` in REGW: register indices
- `id_aluop` in 4: ALU opcode (0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA, 1000 SLT, 1001 SLTU)
- `id_alusrc`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg` in 1: decoded control
- `flush` in 1: branch/jump resolved taken in EX; kill the instruction in ID
- `hold` in 1: downstream stall; freeze ID/EX contents
- `exmem_regwrite` in 1, `exmem_rd` in REGW: instruction currently in MEM
- `memwb_regwrite` in 1, `memwb_rd` in REGW: instruction currently in WB
- `ex_valid`, `ex_alusrc`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg` out 1: registered control
- `ex_pc`, `ex_a`, `ex_b`, `ex_imm` out XLEN: registered PC, operands, immediate
- `ex_rs1`, `ex_rs2`, `ex_rd` out REGW: registered indices
- `ex_aluop` out 4: registered ALU opcode
- `sel_a`, `sel_b` out 2: forwarding selects (00 register, 01 WB result, 10 EX/MEM ALU result; 11 never driven)
- `stall` out 1: freeze PC and IF/ID this cycle
- `stall_count` out 32: saturating count of load-use bubble cycles

## Operation
- Register update priority on each rising edge: reset, then `flush`, then `hold`, then load-use bubble, then normal load.
- **Flush:** insert a bubble. A bubble sets every registered output to 0, including `ex_valid`.
- **Hold:** all registers retain their values. `stall` = 1 so upstream also freezes.
- **Load-use bubble:** `hazard` = `id_valid & ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2)`. When `hazard` = 1 and there is no flush or hold, insert a bubble and assert `stall`. ID retains its instruction and reissues it next cycle.
- **Normal load:** all `id_*` fields are captured into `ex_*`. `ex_valid` = `id_valid`. When `id_valid` = 0, control bits are captured as 0.
- `stall` (combinational) = `~flush & (hold | hazard)`. Flush overrides stall because the ID instruction is dead.
- `sel_a` (combinational, from registered `ex_rs1`):
  - 10 if `exmem_regwrite & exmem_rd != 0 & exmem_rd == ex_rs1`
  - else 01 if `memwb_regwrite & memwb_rd != 0 & memwb_rd == ex_rs1`
  - else 00
- `sel_b` is identical, using `ex_rs2`. EX/MEM has priority over MEM/WB. x0 never forwards.
- Selects are driven regardless of `ex_valid`. The ALU output is don't-care in a bubble.
- `stall_count` increments by 1 on each edge where a load-use bubble is inserted. It saturates at 0xFFFFFFFF and does not count hold or flush cycles.

## Timing
- Reset (`reset_n` = 0, asynchronous): all `ex_*` outputs = 0 and `stall_count` = 0. `sel_a`/`sel_b` = 00 because `ex_rs*` = 0.
- Reset asserted mid-operation clears the stage immediately, without waiting for a clock edge.
- Latency: an ID instruction appears on `ex_*` one cycle after capture.
- A load-use hazard costs exactly one bubble cycle. On the next cycle `ex_memread` = 0, so `hazard` = 0. The dependent instruction then enters EX and receives `sel` = 10 or 01 via the existing paths.
- `flush` and `hazard` in the same cycle: bubble inserted, `stall` = 0, `stall_count` unchanged.
- `flush` and `hold` in the same cycle: bubble inserted, `stall` = 0.
- `hold` and `hazard` in the same cycle: contents frozen, `stall` = 1, `stall_count` unchanged.
- `stall`, `sel_a` and `sel_b` are combinational from registered state plus current inputs, with no internal feedback loops.

## Test plan
- Reset then load: pulse `reset_n` low, release, drive ADD (`id_rs1`=1, `id_rs1_data`=5, `id_rs2`=2, `id_rs2_data`=7, `id_rd`=3, `id_aluop`=0010, `id_valid`=1) -> all outputs 0 during reset; next edge `ex_a`=5, `ex_b`=7, `ex_aluop`=0010, `ex_valid`=1.
- Forwarding priority: `ex_rs1`=3, `exmem_rd`=3, `memwb_rd`=3, both regwrite=1 -> `sel_a`=10. Drop `exmem_regwrite` -> `sel_a`=01. Set all rd=0 -> `sel_a`=00.
- Load-use: LW x5 in EX (`ex_memread`=1, `ex_rd`=5), ID has `id_rs2`=5 -> `stall`=1, next edge bubble (`ex_valid`=0), `stall_count`=1. Following edge the dependent instruction loads with `stall`=0.
- Flush plus hazard in the same cycle -> `stall`=0, bubble inserted, `stall_count` unchanged.
- Hold for 3 cycles with a valid instruction in EX -> `ex_*` unchanged each cycle, `stall`=1. Release -> normal load resumes.
- Asynchronous reset asserted mid-stall (between clock edges) -> outputs clear immediately, `stall_count`=0, `stall`=0 once `ex_valid`=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding-select and load-use hazard logic; one cycle ID->EX latency.
// Backpressure: hold freezes the stage, a load-use hazard inserts one bubble, and both raise stall unless flush kills ID.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [3:0]      id_aluop,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,

    input  logic            flush,
    input  logic            hold,

    input  logic            exmem_regwrite,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            memwb_regwrite,
    input  logic [REGW-1:0] memwb_rd,

    output logic            ex_valid,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic [3:0]      ex_aluop,

    output logic [1:0]      sel_a,
    output logic [1:0]      sel_b,
    output logic            stall,
    output logic [31:0]     stall_count
);

    typedef struct packed {
        logic            valid;
        logic            alusrc;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic [3:0]      aluop;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
    } ex_t;

    ex_t         ex_q;
    ex_t         ex_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        hazard;

    // EX/MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REGW-1:0] rs,
        input logic            mem_we,
        input logic [REGW-1:0] mem_rd,
        input logic            wb_we,
        input logic [REGW-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        hazard = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0)
               & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
        stall  = ~flush & (hold | hazard);
        sel_a  = fwd_sel(ex_q.rs1, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
        sel_b  = fwd_sel(ex_q.rs2, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
    end

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (!hold) begin
            if (hazard) begin
                ex_d = '0;
                if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end else begin
                // Non-valid slots carry no side effects, so their control bits are zeroed.
                ex_d.valid    = id_valid;
                ex_d.alusrc   = id_valid & id_alusrc;
                ex_d.regwrite = id_valid & id_regwrite;
                ex_d.memread  = id_valid & id_memread;
                ex_d.memwrite = id_valid & id_memwrite;
                ex_d.memtoreg = id_valid & id_memtoreg;
                ex_d.aluop    = id_aluop;
                ex_d.rs1      = id_rs1;
                ex_d.rs2      = id_rs2;
                ex_d.rd       = id_rd;
                ex_d.pc       = id_pc;
                ex_d.a        = id_rs1_data;
                ex_d.b        = id_rs2_data;
                ex_d.imm      = id_imm;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_pc       = ex_q.pc;
    assign ex_a        = ex_q.a;
    assign ex_b        = ex_q.b;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_aluop    = ex_q.aluop;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_aluop;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        flush, hold;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;

    logic        ex_valid, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_aluop;
    logic [1:0]  sel_a, sel_b;
    logic        stall;
    logic [31:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    // Expected contents of the EX slot and bubble counter
    logic        m_valid, m_alusrc, m_regwrite, m_memread, m_memwrite, m_memtoreg;
    logic [31:0] m_pc, m_a, m_b, m_imm, m_cnt;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_aluop;

    id_ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .flush(flush), .hold(hold),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_aluop(ex_aluop),
        .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_valid, m_alusrc, m_regwrite, m_memread, m_memwrite, m_memtoreg} = '0;
        {m_pc, m_a, m_b, m_imm, m_cnt} = '0;
        {m_rs1, m_rs2, m_rd, m_aluop} = '0;
    endtask

    function automatic logic m_hazard();
        return id_valid && m_valid && m_memread && m_rd != 0 &&
               (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    function automatic logic [1:0] m_sel(input logic [4:0] rs);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return 2'd2;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_clock();
        if (flush) begin
            model_reset_slot();
        end else if (hold) begin
            // contents kept as they are
        end else if (m_hazard()) begin
            model_reset_slot();
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid;
            m_alusrc = id_valid && id_alusrc;     m_regwrite = id_valid && id_regwrite;
            m_memread = id_valid && id_memread;   m_memwrite = id_valid && id_memwrite;
            m_memtoreg = id_valid && id_memtoreg;
            m_pc = id_pc; m_a = id_rs1_data; m_b = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_aluop = id_aluop;
        end
    endtask

    task automatic model_reset_slot();
        logic [31:0] keep;
        keep = m_cnt;
        model_reset();
        m_cnt = keep;
    endtask

    task automatic check_comb();
        chk("stall", stall, !flush && (hold || m_hazard()));
        chk("sel_a", sel_a, m_sel(m_rs1));
        chk("sel_b", sel_b, m_sel(m_rs2));
    endtask

    task automatic check_regs();
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_ctrl", {ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
            {m_alusrc, m_regwrite, m_memread, m_memwrite, m_memtoreg});
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_a", ex_a, m_a);
        chk("ex_b", ex_b, m_b);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_idx", {ex_rs1, ex_rs2, ex_rd}, {m_rs1, m_rs2, m_rd});
        chk("ex_aluop", ex_aluop, m_aluop);
        chk("stall_count", stall_count, m_cnt);
    endtask

    // Called shortly after a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        #1;
        check_comb();
        @(posedge clk);
        model_clock();
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic clear_in();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_aluop = 0;
        id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
        flush = 0; hold = 0;
        exmem_regwrite = 0; exmem_rd = 0; memwb_regwrite = 0; memwb_rd = 0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic mr);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_memread = mr;
        id_regwrite = 1; id_memtoreg = mr; id_pc = $urandom;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    endtask

    task automatic rnd_in();
        id_valid = ($urandom_range(0, 3) != 0);
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3)); id_aluop = 4'($urandom);
        id_alusrc = 1'($urandom); id_regwrite = 1'($urandom); id_memread = 1'($urandom);
        id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
        flush = ($urandom_range(0, 7) == 0);
        hold = ($urandom_range(0, 7) == 0);
        exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
        memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
    endtask

    initial begin
        clear_in();
        model_reset();
        reset_n = 0;
        @(negedge clk);
        id_valid = 1; id_rs1 = 1; id_rs1_data = 5;
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_a", ex_a, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_sel_a", sel_a, 0);
        @(negedge clk);
        reset_n = 1;

        // ADD x3, x1, x2
        clear_in();
        id_valid = 1; id_rs1 = 1; id_rs1_data = 5; id_rs2 = 2; id_rs2_data = 7;
        id_rd = 3; id_aluop = 4'b0010; id_regwrite = 1;
        step();
        chk("add_a", ex_a, 5);
        chk("add_b", ex_b, 7);
        chk("add_op", ex_aluop, 4'b0010);
        chk("add_valid", ex_valid, 1);

        // Forwarding priority on ex_rs1 = 3
        set_instr(3, 4, 6, 0);
        step();
        exmem_regwrite = 1; exmem_rd = 3; memwb_regwrite = 1; memwb_rd = 3;
        #1 chk("fwd_mem", sel_a, 2'b10);
        exmem_regwrite = 0;
        #1 chk("fwd_wb", sel_a, 2'b01);
        exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        #1 chk("fwd_x0", sel_a, 2'b00);
        step();
        clear_in();

        // Load-use: LW x5, then consumer of x5 in rs2
        set_instr(0, 0, 5, 1);
        step();
        set_instr(1, 5, 6, 0);
        #1 chk("lu_stall", stall, 1);
        step();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_cnt", stall_count, 1);
        step();
        chk("lu_reload", ex_valid, 1);
        chk("lu_rd", ex_rd, 6);

        // Flush together with a hazard
        set_instr(0, 0, 5, 1);
        step();
        set_instr(5, 0, 7, 0);
        flush = 1;
        #1 chk("fh_stall", stall, 0);
        step();
        chk("fh_bubble", ex_valid, 0);
        chk("fh_cnt", stall_count, 1);
        flush = 0;

        // Hold three cycles with a valid instruction in EX
        set_instr(2, 3, 4, 0);
        step();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(5'(i + 5), 1, 9, 1);
            step();
        end
        hold = 0;
        step();

        // Asynchronous reset between edges while a load-use stall is pending
        set_instr(0, 0, 5, 1);
        step();
        set_instr(5, 0, 8, 0);
        #1 chk("ar_stall_pre", stall, 1);
        #2 reset_n = 0;
        #1;
        chk("ar_valid", ex_valid, 0);
        chk("ar_memread", ex_memread, 0);
        chk("ar_cnt", stall_count, 0);
        chk("ar_stall", stall, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 400; i++) begin
            rnd_in();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
